regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Multi-cycle instruction sequencer that drives the CPU's 16x16 register file: one write port, two registered read ports.
- Accepts one 16-bit instruction per valid/ready handshake, reads operands, executes a small ALU op and writes the result back.
- Sits between the instruction source (fetch unit or testbench) and the register file.
- The only master of the register file's we, address and data inputs.

Parameters:
DATA_W, 16, register/data width
ADDR_W, 4, register address width (16 registers)
OPC_W, 4, opcode width; instruction width = OPC_W + 3*ADDR_W = 16

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (IDLE only)
instr_data  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4; LDI uses [7:0] as imm8
rf_we  out  1  register file write enable
rf_addr_write  out  4  write address
rf_addr_read1  out  4  read address 1
rf_addr_read2  out  4  read address 2
rf_data_in  out  16  write data
rf_data_out1  in  16  read data 1, valid the cycle after address is presented
rf_data_out2  in  16  read data 2, same timing
done  out  1  one-cycle pulse when an instruction retires
result  out  16  last written-back value, held
zero_flag  out  1  result==0 at last write-back
carry_flag  out  1  carry/borrow of last ADD/SUB
illegal  out  1  one-cycle pulse on an undefined opcode
halted  out  1  high in HALTED

Behaviour:
- Reset: at a posedge with reset_n=0, go to IDLE. Clear the instruction register, result, zero_flag, carry_flag, done, illegal and rf_we. Reset overrides everything, including a WRITE in progress; rf_we=0 from the next cycle.
- Handshake: instr_ready=1 exactly in IDLE. Accept when instr_valid && instr_ready at a posedge and latch instr_data. instr_data is don't-care otherwise.
- States: IDLE, READ, EXEC, WRITE, HALTED.
- IDLE, on accept:
  - ALU ops, MOV, SHL, SHR -> READ.
  - LDI -> WRITE.
  - NOP -> IDLE with a done pulse.
  - HALT -> HALTED with a done pulse.
  - Undefined opcode -> IDLE with done and illegal pulses; no write.
- READ: rf_addr_read1=rs1, rf_addr_read2=rs2 (combinational from the latched instruction; also held in EXEC). -> EXEC.
- EXEC: rf_data_out1/2 are valid. Compute and register the 17-bit result via seq_alu. -> WRITE.
- WRITE: rf_we=1, rf_addr_write=rd, rf_data_in=registered result. At the end of the cycle, update result/zero_flag/carry_flag and pulse done the following cycle. -> IDLE.
- Latency, accept edge to write-enable cycle: ALU ops 3 cycles, LDI 1 cycle. Next accept is possible the cycle after WRITE.
- Opcodes:
  - 0 NOP
  - 1 ADD: {c,r}=a+b
  - 2 SUB: r=a-b, c=(a<b unsigned)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 MOV: r=a
  - 7 LDI: r={8'h00,imm8}
  - 8 SHL: r=a<<imm4
  - 9 SHR: r=a>>imm4, logical
  - F HALT
  - A-E undefined
- Flags: carry_flag is updated only by ADD/SUB and holds otherwise. zero_flag is updated on every write-back.
- Wrap-around: ADD/SUB results are modulo 2^16; the carry/borrow is captured in carry_flag.
- rd may equal rs1/rs2; the write happens after the read, so there is no hazard. r0 is an ordinary register.
- HALTED: instr_ready=0, rf_we=0, halted=1. Leaves only through reset.
- Outside WRITE: rf_we=0, rf_addr_write=0, rf_data_in=0. Read addresses are 0 in IDLE and HALTED.

Decomposition:
- Package regfile_seq_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT)
  - state encoding (IDLE, READ, EXEC, WRITE, HALTED)
  - instruction field bit positions
- Sub-module seq_alu: combinational, opcode + a + b + imm -> 17-bit {carry,result}.
- The FSM and registers stay in regfile_sequencer.

Test Plan:
- Bench wires the sequencer to the register file. LDI r1,0x34; LDI r2,0x12 -> two writes; r1=0x0034, r2=0x0012; zero_flag=0; each rf_we asserted 1 cycle after accept.
- Preload r3=0x00FF, r4=0x0001 via LDI; ADD r5,r3,r4 -> r5=0x0100, carry=0. Preload r3=0xFFFF (0x00FF SHL 8 then OR 0x00FF); ADD r5,r3,r4 -> r5=0x0000, zero=1, carry=1. rf_we exactly 3 cycles after the ADD accept edge.
- SUB r6,r4,r3 with r4=1, r3=2 -> r6=0xFFFF, carry=1. Then AND r6,r6,r0 (r0=0) -> r6=0, zero=1, carry unchanged.
- Back-to-back: instr_valid held high with 5 instructions queued -> instr_ready low in READ/EXEC/WRITE. Each instruction is accepted exactly once and retired in order. No rf_we outside WRITE.
- Opcode 0xB -> illegal and done pulse, no rf_we, back to IDLE. HALT -> halted=1, instr_ready=0 for 20 cycles despite instr_valid=1.
- Assert reset_n=0 for one edge during EXEC of an ADD -> no write occurs. State is IDLE with instr_ready=1 and flags cleared on the next cycle, and halted is cleared.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: opcodes, FSM states and instruction field positions for regfile_sequencer
package regfile_seq_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, HALTED} state_t;
endpackage

// File: rtl/regfile_sequencer_alu.sv
// seq_alu: combinational ALU returning {carry, result}; carry is the ADD carry or SUB borrow
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic [OPC_W-1:0]  i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [ADDR_W-1:0] i_imm,
  output logic [DATA_W:0]   o_y
);
  logic [DATA_W:0] w_a;
  logic [DATA_W:0] w_b;
  assign w_a = {1'b0, i_a};
  assign w_b = {1'b0, i_b};
  // zero-extended subtraction leaves the unsigned borrow in the top bit
  always_comb
    o_y = i_op == OP_ADD ? w_a + w_b :
          i_op == OP_SUB ? w_a - w_b :
          i_op == OP_AND ? w_a & w_b :
          i_op == OP_OR  ? w_a | w_b :
          i_op == OP_XOR ? w_a ^ w_b :
          i_op == OP_MOV ? w_a :
          i_op == OP_SHL ? {1'b0, i_a << i_imm} :
          i_op == OP_SHR ? w_a >> i_imm : '0;
endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle fetch/read/exec/write sequencer driving a 16x16 register file
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [OPC_W+3*ADDR_W-1:0]   instr_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_addr_write,
  output logic [ADDR_W-1:0]           rf_addr_read1,
  output logic [ADDR_W-1:0]           rf_addr_read2,
  output logic [DATA_W-1:0]           rf_data_in,
  input  logic [DATA_W-1:0]           rf_data_out1,
  input  logic [DATA_W-1:0]           rf_data_out2,
  output logic                        done,
  output logic [DATA_W-1:0]           result,
  output logic                        zero_flag,
  output logic                        carry_flag,
  output logic                        illegal,
  output logic                        halted
);
  state_t                      r_state;
  logic [OPC_W+3*ADDR_W-1:0]   r_instr;
  logic [DATA_W:0]             r_alu;
  logic [DATA_W:0]             w_alu;
  logic [OPC_W-1:0]            w_opc;
  logic [OPC_W-1:0]            w_in_opc;
  logic [ADDR_W-1:0]           w_rd;
  logic [ADDR_W-1:0]           w_rs1;
  logic [ADDR_W-1:0]           w_rs2;
  logic                        w_rd_phase;
  assign w_opc      = r_instr[OPC_LSB +: OPC_W];
  assign w_in_opc   = instr_data[OPC_LSB +: OPC_W];
  assign w_rd       = r_instr[RD_LSB +: ADDR_W];
  assign w_rs1      = r_instr[RS1_LSB +: ADDR_W];
  assign w_rs2      = r_instr[RS2_LSB +: ADDR_W];
  assign w_rd_phase = r_state == READ || r_state == EXEC;
  assign instr_ready   = r_state == IDLE;
  assign halted        = r_state == HALTED;
  assign rf_we         = r_state == WRITE;
  assign rf_addr_write = rf_we ? w_rd : '0;
  assign rf_data_in    = rf_we ? r_alu[DATA_W-1:0] : '0;
  assign rf_addr_read1 = w_rd_phase ? w_rs1 : '0;
  assign rf_addr_read2 = w_rd_phase ? w_rs2 : '0;
  seq_alu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) u_alu (
    .i_op  (w_opc),
    .i_a   (rf_data_out1),
    .i_b   (rf_data_out2),
    .i_imm (w_rs2),
    .o_y   (w_alu)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_alu      <= '0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (r_state)
        IDLE: if (instr_valid) begin
          r_instr <= instr_data;
          // LDI skips the read/exec phases, so its immediate is staged here
          r_alu   <= {{(DATA_W-7){1'b0}}, instr_data[7:0]};
          if (w_in_opc == OP_LDI) r_state <= WRITE;
          else if (w_in_opc == OP_NOP) done <= 1'b1;
          else if (w_in_opc == OP_HALT) begin
            done    <= 1'b1;
            r_state <= HALTED;
          end else if (w_in_opc > OP_SHR) begin
            done    <= 1'b1;
            illegal <= 1'b1;
          end else r_state <= READ;
        end
        READ: r_state <= EXEC;
        EXEC: begin
          r_alu   <= w_alu;
          r_state <= WRITE;
        end
        WRITE: begin
          result    <= r_alu[DATA_W-1:0];
          zero_flag <= r_alu[DATA_W-1:0] == '0;
          if (w_opc == OP_ADD || w_opc == OP_SUB) carry_flag <= r_alu[DATA_W];
          done      <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= r_state;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed bench with a behavioural 16x16 register file behind the sequencer
module tb_regfile_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr_data = '0;
  logic        rf_we;
  logic [3:0]  rf_addr_write, rf_addr_read1, rf_addr_read2;
  logic [15:0] rf_data_in;
  logic [15:0] rf_data_out1 = '0, rf_data_out2 = '0;
  logic        done, zero_flag, carry_flag, illegal, halted;
  logic [15:0] result;
  logic [15:0] mem [16] = '{default: 16'h0};
  int          tests = 0;
  int          fails = 0;
  int          n_wr = 0;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .rf_we(rf_we), .rf_addr_write(rf_addr_write),
    .rf_addr_read1(rf_addr_read1), .rf_addr_read2(rf_addr_read2), .rf_data_in(rf_data_in),
    .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2), .done(done), .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .illegal(illegal), .halted(halted)
  );

  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_addr_write] <= rf_data_in;
      n_wr <= n_wr + 1;
    end
    rf_data_out1 <= mem[rf_addr_read1];
    rf_data_out2 <= mem[rf_addr_read2];
  end

  function automatic logic [15:0] op(input logic [3:0] o, rd, a, b);
    return {o, rd, a, b};
  endfunction

  function automatic logic [15:0] ld(input logic [3:0] rd, input logic [7:0] imm);
    return {4'h7, rd, imm};
  endfunction

  task automatic send(input logic [15:0] ins, input string tag);
    int i = 0;
    while (instr_ready !== 1'b1 && i < 50) begin @(negedge clk); i++; end
    tests++;
    if (instr_ready !== 1'b1) begin fails++; $display("FAIL %s_ready: got %b want 1", tag, instr_ready); end
    instr_valid = 1'b1;
    instr_data  = ins;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (done !== 1'b1 && i < 10) begin @(negedge clk); i++; end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL %s_done: timeout, done=%b want 1", tag, done); end
  endtask

  task automatic run(input logic [15:0] ins, input string tag);
    send(ins, tag);
    wait_done(tag);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", rf_we); end
    tests++; if (result !== 16'h0) begin fails++; $display("FAIL rst_result: got %h want 0000", result); end
    tests++; if ({done, illegal, halted, zero_flag, carry_flag} !== 5'b0) begin
      fails++; $display("FAIL rst_flags: got %b want 00000", {done, illegal, halted, zero_flag, carry_flag}); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ldi;
    send(ld(4'd1, 8'h34), "ldi1");
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL ldi1_we: got %b want 1", rf_we); end
    tests++; if (rf_addr_write !== 4'd1) begin fails++; $display("FAIL ldi1_addr: got %h want 1", rf_addr_write); end
    tests++; if (rf_data_in !== 16'h0034) begin fails++; $display("FAIL ldi1_data: got %h want 0034", rf_data_in); end
    wait_done("ldi1");
    tests++; if (result !== 16'h0034) begin fails++; $display("FAIL ldi1_result: got %h want 0034", result); end
    tests++; if (zero_flag !== 1'b0) begin fails++; $display("FAIL ldi1_zero: got %b want 0", zero_flag); end
    send(ld(4'd2, 8'h12), "ldi2");
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL ldi2_we: got %b want 1", rf_we); end
    tests++; if (rf_data_in !== 16'h0012) begin fails++; $display("FAIL ldi2_data: got %h want 0012", rf_data_in); end
    wait_done("ldi2");
    tests++; if (mem[1] !== 16'h0034) begin fails++; $display("FAIL ldi_r1: got %h want 0034", mem[1]); end
    tests++; if (mem[2] !== 16'h0012) begin fails++; $display("FAIL ldi_r2: got %h want 0012", mem[2]); end
  endtask

  task automatic test_add;
    run(ld(4'd3, 8'hFF), "pre_r3");
    run(ld(4'd4, 8'h01), "pre_r4");
    send(op(4'h1, 4'd5, 4'd3, 4'd4), "add1");
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL add1_we_c1: got %b want 0", rf_we); end
    @(negedge clk);
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL add1_we_c2: got %b want 0", rf_we); end
    @(negedge clk);
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL add1_we_c3: got %b want 1", rf_we); end
    tests++; if (rf_addr_write !== 4'd5) begin fails++; $display("FAIL add1_addr: got %h want 5", rf_addr_write); end
    tests++; if (rf_data_in !== 16'h0100) begin fails++; $display("FAIL add1_data: got %h want 0100", rf_data_in); end
    wait_done("add1");
    tests++; if (result !== 16'h0100) begin fails++; $display("FAIL add1_result: got %h want 0100", result); end
    tests++; if ({zero_flag, carry_flag} !== 2'b00) begin fails++; $display("FAIL add1_flags: got %b want 00", {zero_flag, carry_flag}); end
    run(op(4'h8, 4'd3, 4'd3, 4'd8), "shl");
    tests++; if (result !== 16'hFF00) begin fails++; $display("FAIL shl_result: got %h want ff00", result); end
    run(ld(4'd7, 8'hFF), "pre_r7");
    run(op(4'h4, 4'd3, 4'd3, 4'd7), "or");
    tests++; if (result !== 16'hFFFF) begin fails++; $display("FAIL or_result: got %h want ffff", result); end
    send(op(4'h1, 4'd5, 4'd3, 4'd4), "add2");
    repeat (2) @(negedge clk);
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL add2_we_c3: got %b want 1", rf_we); end
    wait_done("add2");
    tests++; if (result !== 16'h0000) begin fails++; $display("FAIL add2_result: got %h want 0000", result); end
    tests++; if ({zero_flag, carry_flag} !== 2'b11) begin fails++; $display("FAIL add2_flags: got %b want 11", {zero_flag, carry_flag}); end
    tests++; if (mem[5] !== 16'h0000) begin fails++; $display("FAIL add2_r5: got %h want 0000", mem[5]); end
  endtask

  task automatic test_sub;
    run(ld(4'd3, 8'h02), "pre_r3b");
    run(op(4'h2, 4'd6, 4'd4, 4'd3), "sub");
    tests++; if (result !== 16'hFFFF) begin fails++; $display("FAIL sub_result: got %h want ffff", result); end
    tests++; if ({zero_flag, carry_flag} !== 2'b01) begin fails++; $display("FAIL sub_flags: got %b want 01", {zero_flag, carry_flag}); end
    run(op(4'h3, 4'd6, 4'd6, 4'd0), "and");
    tests++; if (result !== 16'h0000) begin fails++; $display("FAIL and_result: got %h want 0000", result); end
    tests++; if ({zero_flag, carry_flag} !== 2'b11) begin fails++; $display("FAIL and_flags: got %b want 11", {zero_flag, carry_flag}); end
    tests++; if (mem[6] !== 16'h0000) begin fails++; $display("FAIL and_r6: got %h want 0000", mem[6]); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q   [5] = '{16'h5812, 16'h6980, 16'h8A94, 16'h9BA5, 16'h7C80};
    logic [15:0] exp [5] = '{16'h0026, 16'h0026, 16'h0260, 16'h0013, 16'h0080};
    int acc = 0, ret = 0, viol = 0, w0;
    @(negedge clk);
    w0 = n_wr;
    instr_valid = 1'b1;
    instr_data  = q[0];
    for (int c = 0; c < 100 && ret < 5; c++) begin
      if (done === 1'b1) begin
        tests++;
        if (result !== exp[ret]) begin fails++; $display("FAIL b2b_ret%0d: got %h want %h", ret, result, exp[ret]); end
        ret++;
      end
      if (rf_we === 1'b1 && instr_ready !== 1'b0) viol++;
      if (instr_ready === 1'b1 && instr_valid) begin
        acc++;
        @(posedge clk);
        #1;
        if (acc < 5) instr_data = q[acc];
        else instr_valid = 1'b0;
      end
      if (ret < 5) @(negedge clk);
    end
    instr_valid = 1'b0;
    tests++; if (ret !== 5) begin fails++; $display("FAIL b2b_retired: got %0d want 5", ret); end
    tests++; if (acc !== 5) begin fails++; $display("FAIL b2b_accepted: got %0d want 5", acc); end
    tests++; if (viol !== 0) begin fails++; $display("FAIL b2b_ready_in_write: got %0d want 0", viol); end
    tests++; if (n_wr - w0 !== 5) begin fails++; $display("FAIL b2b_writes: got %0d want 5", n_wr - w0); end
    tests++; if (mem[11] !== 16'h0013) begin fails++; $display("FAIL b2b_r11: got %h want 0013", mem[11]); end
  endtask

  task automatic test_illegal;
    int w0 = n_wr;
    send(16'hB123, "ill");
    tests++; if ({done, illegal} !== 2'b11) begin fails++; $display("FAIL ill_pulse: got %b want 11", {done, illegal}); end
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL ill_we: got %b want 0", rf_we); end
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL ill_ready: got %b want 1", instr_ready); end
    @(negedge clk);
    tests++; if ({done, illegal} !== 2'b00) begin fails++; $display("FAIL ill_onecycle: got %b want 00", {done, illegal}); end
    @(negedge clk);
    tests++; if (n_wr !== w0) begin fails++; $display("FAIL ill_writes: got %0d want %0d", n_wr, w0); end
  endtask

  task automatic test_halt;
    int w0 = n_wr, bad = 0;
    send(16'hF000, "halt");
    tests++; if ({done, halted} !== 2'b11) begin fails++; $display("FAIL halt_pulse: got %b want 11", {done, halted}); end
    instr_valid = 1'b1;
    instr_data  = ld(4'd1, 8'h55);
    repeat (20) begin
      @(negedge clk);
      if (instr_ready !== 1'b0 || rf_we !== 1'b0 || halted !== 1'b1) bad++;
    end
    instr_valid = 1'b0;
    tests++; if (bad !== 0) begin fails++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
    tests++; if (n_wr !== w0) begin fails++; $display("FAIL halt_writes: got %0d want %0d", n_wr, w0); end
    tests++; if (mem[1] !== 16'h0034) begin fails++; $display("FAIL halt_r1: got %h want 0034", mem[1]); end
  endtask

  task automatic test_reset_exec;
    int w0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tests++; if ({halted, instr_ready} !== 2'b01) begin fails++; $display("FAIL unhalt: got %b want 01", {halted, instr_ready}); end
    run(op(4'h2, 4'd13, 4'd0, 4'd4), "pre_sub");
    tests++; if ({result, carry_flag} !== {16'hFFFF, 1'b1}) begin
      fails++; $display("FAIL pre_sub: got %h/%b want ffff/1", result, carry_flag); end
    w0 = n_wr;
    send(op(4'h1, 4'd5, 4'd3, 4'd4), "add_rst");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rstx_we: got %b want 0", rf_we); end
    tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL rstx_ready: got %b want 1", instr_ready); end
    tests++; if ({zero_flag, carry_flag, done, halted} !== 4'b0) begin
      fails++; $display("FAIL rstx_flags: got %b want 0000", {zero_flag, carry_flag, done, halted}); end
    tests++; if (result !== 16'h0) begin fails++; $display("FAIL rstx_result: got %h want 0000", result); end
    repeat (3) @(negedge clk);
    tests++; if (n_wr !== w0) begin fails++; $display("FAIL rstx_writes: got %0d want %0d", n_wr, w0); end
    tests++; if (mem[5] !== 16'h0000) begin fails++; $display("FAIL rstx_r5: got %h want 0000", mem[5]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_ldi;
    test_add;
    test_sub;
    test_back_to_back;
    test_illegal;
    test_halt;
    test_reset_exec;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
